// File: rtl/coef_load_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : coef_load_sequencer
// Description : Host-side coefficient loader. Routes LRECOVERY sign-extended
//               words to each of the T-red, T-green, T-blue and lambda shift
//               registers in turn, then issues a single commit pulse on the
//               host COMMIT command. Reports busy/done/error status.
//               Optional macro COEF_LOAD_CHECKSUM_EN adds a 16-bit running
//               checksum that COMMIT verifies against command[31:16].
// Revision    : 1.0 - initial release
// ============================================================================
module coef_load_sequencer #(
  parameter int LRECOVERY = 1024,
  parameter int WORDWIDTH = 16,
  parameter int CNTWIDTH  = (LRECOVERY > 1) ? $clog2(LRECOVERY) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         command,
  input  logic                command_new,
  input  logic [31:0]         data_word,
  input  logic                data_word_new,
  output logic [31:0]         data_T_Red,
  output logic [31:0]         data_T_Green,
  output logic [31:0]         data_T_Blue,
  output logic [31:0]         data_lambda,
  output logic                data_T_Red_new,
  output logic                data_T_Green_new,
  output logic                data_T_Blue_new,
  output logic                data_lambda_new,
  output logic                commit_new,
  output logic                busy,
  output logic                done,
  output logic                error,
`ifdef COEF_LOAD_CHECKSUM_EN
  output logic [15:0]         checksum,
`endif
  output logic [CNTWIDTH-1:0] word_count
);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_LOAD_RED    = 3'd1,
    S_LOAD_GREEN  = 3'd2,
    S_LOAD_BLUE   = 3'd3,
    S_LOAD_LAMBDA = 3'd4,
    S_WAIT_COMMIT = 3'd5
  } state_t;

  localparam logic [3:0]          c_OP_START  = 4'd1;
  localparam logic [3:0]          c_OP_ABORT  = 4'd2;
  localparam logic [3:0]          c_OP_COMMIT = 4'd3;
  localparam logic [CNTWIDTH-1:0] c_LAST      = CNTWIDTH'(LRECOVERY - 1);

  state_t              r_state, w_state_next;
  logic [CNTWIDTH-1:0] r_word_count, w_count_next;
  logic [31:0]         r_data [4];
  logic [3:0]          r_strobe, w_strobe_next;
  logic                r_commit, w_commit_next;
  logic                r_busy, w_busy_next;
  logic                r_done, w_done_next;
  logic                r_error, w_error_next;
  logic [1:0]          w_chan;
  logic                w_is_load;
  state_t              w_adv_state;
  logic [31:0]         w_sext;
  logic [15:0]         r_checksum, w_checksum_next;
  logic                w_sum_match;
  logic                w_unused_bits;

  assign w_sext        = 32'($signed(data_word[WORDWIDTH-1:0]));
  // Upper data bits and command bits outside the opcode (and checksum field)
  // carry no meaning here.
  assign w_unused_bits = ^{data_word, command};

`ifdef COEF_LOAD_CHECKSUM_EN
  assign w_sum_match = (r_checksum == command[31:16]);
  assign checksum    = r_checksum;
`else
  assign w_sum_match = 1'b1;
`endif

  // Decode which shift register the current load state feeds and where it advances to.
  always_comb begin
    w_chan      = 2'd0;
    w_is_load   = 1'b1;
    w_adv_state = r_state;
    case (r_state)
      S_LOAD_RED:    begin w_chan = 2'd0; w_adv_state = S_LOAD_GREEN;  end
      S_LOAD_GREEN:  begin w_chan = 2'd1; w_adv_state = S_LOAD_BLUE;   end
      S_LOAD_BLUE:   begin w_chan = 2'd2; w_adv_state = S_LOAD_LAMBDA; end
      S_LOAD_LAMBDA: begin w_chan = 2'd3; w_adv_state = S_WAIT_COMMIT; end
      default:       w_is_load = 1'b0;
    endcase
  end

  // Next-state and next-output logic; commands take precedence over data words.
  always_comb begin
    w_state_next    = r_state;
    w_count_next    = r_word_count;
    w_strobe_next   = 4'b0000;
    w_commit_next   = 1'b0;
    w_done_next     = r_done;
    w_error_next    = r_error;
    w_checksum_next = r_checksum;
    if (command_new) begin
      case (command[3:0])
        c_OP_START: begin
          w_state_next    = S_LOAD_RED;
          w_count_next    = '0;
          w_done_next     = 1'b0;
          w_error_next    = 1'b0;
          w_checksum_next = 16'h0000;
        end
        c_OP_ABORT: begin
          w_state_next = S_IDLE;
          w_count_next = '0;
        end
        c_OP_COMMIT: begin
          if (r_state == S_WAIT_COMMIT) begin
            w_state_next = S_IDLE;
            if (w_sum_match) begin
              w_commit_next = 1'b1;
              w_done_next   = 1'b1;
            end else begin
              w_error_next  = 1'b1;
            end
          end else begin
            w_error_next = 1'b1;
          end
        end
        default: ;
      endcase
      // A colliding data word is dropped and flagged even if START cleared error.
      if (data_word_new) begin
        w_error_next = 1'b1;
      end
    end else if (data_word_new) begin
      if (w_is_load) begin
        w_strobe_next[w_chan] = 1'b1;
        w_checksum_next       = r_checksum + data_word[15:0];
        if (r_word_count == c_LAST) begin
          w_count_next = '0;
          w_state_next = w_adv_state;
        end else begin
          w_count_next = r_word_count + CNTWIDTH'(1);
        end
      end else begin
        w_error_next = 1'b1;
      end
    end
    w_busy_next = (w_state_next == S_LOAD_RED)   || (w_state_next == S_LOAD_GREEN) ||
                  (w_state_next == S_LOAD_BLUE)  || (w_state_next == S_LOAD_LAMBDA);
  end

  // State, status and strobe registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_word_count <= '0;
      r_strobe     <= 4'b0000;
      r_commit     <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_word_count <= w_count_next;
      r_strobe     <= w_strobe_next;
      r_commit     <= w_commit_next;
      r_busy       <= w_busy_next;
      r_done       <= w_done_next;
      r_error      <= w_error_next;
    end
  end

  // Coefficient data registers hold their value until their channel strobes again.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) r_data[i] <= 32'h0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_strobe_next[i]) r_data[i] <= w_sext;
      end
    end
  end

`ifdef COEF_LOAD_CHECKSUM_EN
  // Running 16-bit wrapping sum of accepted words.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_checksum <= 16'h0000;
    else      r_checksum <= w_checksum_next;
  end
`else
  assign r_checksum = 16'h0000;
`endif

  assign data_T_Red       = r_data[0];
  assign data_T_Green     = r_data[1];
  assign data_T_Blue      = r_data[2];
  assign data_lambda      = r_data[3];
  assign data_T_Red_new   = r_strobe[0];
  assign data_T_Green_new = r_strobe[1];
  assign data_T_Blue_new  = r_strobe[2];
  assign data_lambda_new  = r_strobe[3];
  assign commit_new       = r_commit;
  assign busy             = r_busy;
  assign done             = r_done;
  assign error            = r_error;
  assign word_count       = r_word_count;

endmodule
`default_nettype wire

// File: tb/tb_coef_load_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_coef_load_sequencer
// Description : Scoreboard bench for coef_load_sequencer with LRECOVERY=4.
//               Stimulus pushes expected strobes/commits; a monitor pops them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_coef_load_sequencer;

  localparam int LREC = 4;
  localparam int CW   = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   command = '0;
  logic          command_new = 1'b0;
  logic [31:0]   data_word = '0;
  logic          data_word_new = 1'b0;
  logic [31:0]   data_T_Red, data_T_Green, data_T_Blue, data_lambda;
  logic          data_T_Red_new, data_T_Green_new, data_T_Blue_new, data_lambda_new;
  logic          commit_new, busy, done, error;
  logic [CW-1:0] word_count;
`ifdef COEF_LOAD_CHECKSUM_EN
  logic [15:0]   checksum;
`endif

  int total = 0;
  int bad   = 0;
  logic [33:0] exp_q[$];   // {channel[1:0], data[31:0]}
  int commit_exp = 0;

  coef_load_sequencer #(.LRECOVERY(LREC), .WORDWIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .command(command), .command_new(command_new),
    .data_word(data_word), .data_word_new(data_word_new),
    .data_T_Red(data_T_Red), .data_T_Green(data_T_Green),
    .data_T_Blue(data_T_Blue), .data_lambda(data_lambda),
    .data_T_Red_new(data_T_Red_new), .data_T_Green_new(data_T_Green_new),
    .data_T_Blue_new(data_T_Blue_new), .data_lambda_new(data_lambda_new),
    .commit_new(commit_new), .busy(busy), .done(done), .error(error),
`ifdef COEF_LOAD_CHECKSUM_EN
    .checksum(checksum),
`endif
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: actual=0x%08h expected=0x%08h", name, act, expv);
    end
  endtask

  // Monitor: pop an expectation for every strobe and commit pulse the DUT shows.
  always @(negedge clk) begin
    logic [3:0]  strb;
    logic [33:0] e;
    logic [31:0] act;
    logic [1:0]  ch;
    if (rst) begin
      strb = {data_lambda_new, data_T_Blue_new, data_T_Green_new, data_T_Red_new};
      if (strb != 4'b0) begin
        total++;
        if ($countones(strb) != 1 || exp_q.size() == 0) begin
          bad++;
          $display("FAIL strobe: actual strobes=%b expected queue depth=%0d", strb, exp_q.size());
          if (exp_q.size() != 0) e = exp_q.pop_front();
        end else begin
          e = exp_q.pop_front();
          case (strb)
            4'b0001: begin ch = 2'd0; act = data_T_Red;   end
            4'b0010: begin ch = 2'd1; act = data_T_Green; end
            4'b0100: begin ch = 2'd2; act = data_T_Blue;  end
            default: begin ch = 2'd3; act = data_lambda;  end
          endcase
          if (ch != e[33:32] || act != e[31:0]) begin
            bad++;
            $display("FAIL strobe: actual ch=%0d data=0x%08h expected ch=%0d data=0x%08h",
                     ch, act, e[33:32], e[31:0]);
          end
        end
      end
      if (commit_new) begin
        total++;
        if (commit_exp == 0) begin
          bad++;
          $display("FAIL commit: actual pulse=1 expected pulse=0");
        end else begin
          commit_exp--;
        end
      end
    end
  end

  task automatic send_word(input logic [31:0] w, input int ch, input logic [31:0] expd);
    @(negedge clk);
    if (ch >= 0) exp_q.push_back({2'(ch), expd});
    data_word = w; data_word_new = 1'b1;
    @(negedge clk);
    data_word_new = 1'b0;
  endtask

  task automatic send_cmd(input logic [31:0] c, input bit expect_commit);
    @(negedge clk);
    if (expect_commit) commit_exp++;
    command = c; command_new = 1'b1;
    @(negedge clk);
    command_new = 1'b0;
  endtask

  task automatic load_words(input int n, input int first, input logic [31:0] val, input bit seq);
    for (int i = 0; i < n; i++) begin
      logic [31:0] w;
      w = seq ? 32'(first + i) : val;
      send_word(w, (first - 1 + i) / LREC, w);
    end
  endtask

  initial begin
    // Reset state
    #2 rst = 1'b0;
    #2;
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_error", 32'(error), 0);
    chk("reset_wc", 32'(word_count), 0);
    chk("reset_red", data_T_Red, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    // Full load of 1..16 and commit
    send_cmd(32'h1, 0);
    chk("start_busy", 32'(busy), 1);
    load_words(6, 1, 0, 1);
    chk("wc_after6", 32'(word_count), 2);
    load_words(10, 7, 0, 1);
    chk("waitc_busy", 32'(busy), 0);
    chk("waitc_wc", 32'(word_count), 0);
    chk("waitc_error", 32'(error), 0);
    send_cmd(32'h3, 1);
    chk("commit_done", 32'(done), 1);
    chk("commit_error", 32'(error), 0);
    @(negedge clk);
    chk("commit_one_cycle", 32'(commit_new), 0);

    // Sign extension
    send_cmd(32'h1, 0);
    chk("start_clears_done", 32'(done), 0);
    send_word(32'h0000_8003, 0, 32'hFFFF_8003);
    send_word(32'hABCD_7FFF, 0, 32'h0000_7FFF);

    // Abort then commit is an error
    load_words(4, 3, 0, 1);
    chk("abort_pre_wc", 32'(word_count), 2);
    send_cmd(32'h2, 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_wc", 32'(word_count), 0);
    chk("abort_error", 32'(error), 0);
    send_cmd(32'h3, 0);
    chk("commit_idle_error", 32'(error), 1);
    chk("commit_idle_done", 32'(done), 0);
    send_cmd(32'h1, 0);
    chk("restart_error", 32'(error), 0);
    chk("restart_wc", 32'(word_count), 0);

    // Command and data in the same cycle during LOAD_GREEN
    load_words(5, 1, 0, 1);
    chk("green_wc", 32'(word_count), 1);
    @(negedge clk);
    command = 32'h1; command_new = 1'b1;
    data_word = 32'h55; data_word_new = 1'b1;
    @(negedge clk);
    command_new = 1'b0; data_word_new = 1'b0;
    chk("collide_wc", 32'(word_count), 0);
    chk("collide_error", 32'(error), 1);
    chk("collide_busy", 32'(busy), 1);
    send_word(32'h77, 0, 32'h77);   // lands in red: back in LOAD_RED

    // Ignored opcode
    send_cmd(32'h5, 0);
    chk("ignored_wc", 32'(word_count), 1);
    chk("ignored_busy", 32'(busy), 1);

    // Data word in IDLE
    send_cmd(32'h1, 0);
    send_cmd(32'h2, 0);
    send_word(32'h99, -1, 0);
    chk("idle_word_error", 32'(error), 1);

    // Asynchronous reset mid-LOAD_BLUE
    send_cmd(32'h1, 0);
    load_words(9, 1, 0, 1);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("arst_blue", data_T_Blue, 0);
    chk("arst_red", data_T_Red, 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_wc", 32'(word_count), 0);
    @(negedge clk);
    rst = 1'b1;
    send_cmd(32'h3, 0);
    chk("arst_commit_done", 32'(done), 0);
    chk("arst_commit_error", 32'(error), 1);

`ifdef COEF_LOAD_CHECKSUM_EN
    // Checksum match and mismatch
    send_cmd(32'h1, 0);
    load_words(3, 1, 32'h1000, 0);
    chk("cks_partial", 32'(checksum), 32'h3000);
    load_words(13, 4, 32'h1000, 0);
    send_cmd(32'h0000_0003, 1);
    chk("cks_ok_done", 32'(done), 1);
    chk("cks_ok_error", 32'(error), 0);
    send_cmd(32'h1, 0);
    chk("cks_cleared", 32'(checksum), 0);
    load_words(16, 1, 32'h1000, 0);
    send_cmd(32'h1234_0003, 0);
    chk("cks_bad_error", 32'(error), 1);
    chk("cks_bad_done", 32'(done), 0);
    chk("cks_bad_busy", 32'(busy), 0);
`endif

    repeat (3) @(negedge clk);
    chk("strobe_queue_empty", 32'(exp_q.size()), 0);
    chk("commit_queue_empty", 32'(commit_exp), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/coef_load_sequencer.md
Name: coef_load_sequencer

Overview:
- Host-side loader that sits directly upstream of the pixel spectral recovery stage.
- Takes one host data register (word plus strobe) and one host command register (word plus strobe).
- Routes coefficient words, in order, to the T-red, T-green, T-blue and lambda shift-register inputs, counting exactly LRECOVERY words per channel.
- Issues the single-cycle commit pulse that latches the shifted coefficients into the circular buffers, and reports busy/done/error status back to the host.

Parameters:
- LRECOVERY, 1024: coefficients per channel; must equal the downstream LRECOVERY.
- WORDWIDTH, 16: coefficient width; taken from data_word[WORDWIDTH-1:0] and sign-extended to 32 bits.
- CNTWIDTH, clogb2(LRECOVERY): width of the per-channel word counter.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset (0 = reset)
- command  in  32  host command; [3:0] opcode: 1=START, 2=ABORT, 3=COMMIT; [31:16] expected checksum (only with the optional feature)
- command_new  in  1  one-cycle strobe, command valid
- data_word  in  32  host coefficient word
- data_word_new  in  1  one-cycle strobe, data_word valid
- data_T_Red / data_T_Green / data_T_Blue / data_lambda  out  32 each  sign-extended coefficient to the matching shift register
- data_T_Red_new / data_T_Green_new / data_T_Blue_new / data_lambda_new  out  1 each  shift-enable strobes
- commit_new  out  1  one-cycle pulse to the recovery stage's command_new (buffer write)
- busy  out  1  high in the LOAD_* states
- done  out  1  sticky; high after a successful commit
- error  out  1  sticky error flag
- word_count  out  CNTWIDTH  index of the next word within the current channel

Behaviour:
- Reset (rst=0, async): state IDLE; all data outputs 0, all strobes 0, busy=0, done=0, error=0, word_count=0.
- All outputs are registered.
- FSM states: IDLE, LOAD_RED, LOAD_GREEN, LOAD_BLUE, LOAD_LAMBDA, WAIT_COMMIT.
- START from any state: go to LOAD_RED; clear word_count, done and error.
- ABORT from any state: go to IDLE; clear word_count; no strobes; error is not cleared.
- In LOAD_x, each data_word_new:
  - At edge n+1: drive the matching data_T_*/data_lambda with sext(data_word[WORDWIDTH-1:0]) and pulse its _new strobe high for exactly one cycle. Latency is 1 cycle.
  - Increment word_count.
  - On the word with word_count==LRECOVERY-1: wrap word_count to 0 and advance RED→GREEN→BLUE→LAMBDA→WAIT_COMMIT.
- Data outputs hold their last value between strobes. Only one strobe is ever high in a given cycle.
- COMMIT in WAIT_COMMIT: commit_new pulses one cycle at edge n+1, done=1, go to IDLE.
- COMMIT in any other state: error=1, no pulse, state unchanged.
- data_word_new in IDLE or WAIT_COMMIT: word dropped, error=1.
- Opcodes 0 and 4–15: ignored, no state change.
- command_new and data_word_new in the same cycle: command is processed, data word dropped, error=1.
- busy is high only in the LOAD_* states.
- Reset mid-load: immediate return to IDLE; a partial load is never committed.

Optional Feature:
- Macro: COEF_LOAD_CHECKSUM_EN.
- When defined:
  - A 16-bit wrapping sum of data_word[15:0] is accumulated over all 4*LRECOVERY accepted words; it is cleared on START.
  - COMMIT compares the sum against command[31:16]. On a match, behave as above. On a mismatch, error=1, no commit_new, go to IDLE.
  - Adds output port checksum[15:0] holding the running sum; reset value 0.
- When not defined: command[31:16] is ignored, no checksum logic is built, and the port is absent.

Test Plan:
- Run with LRECOVERY=4. START, then 16 words 0x0001..0x0010, then COMMIT:
  - Red strobes carry 1–4, green 5–8, blue 9–12, lambda 13–16.
  - One commit_new pulse one cycle after the COMMIT strobe; done=1; error=0.
- Word 0x0000_8003 to red → data_T_Red=0xFFFF_8003 at the next edge (sign extension, upper bits ignored).
- ABORT after 6 words, then COMMIT → error=1, no commit_new, state IDLE; a following START clears error and word_count.
- command_new (START) and data_word_new in the same cycle during LOAD_GREEN → state LOAD_RED, word_count=0, no data strobe, error=1.
- Assert rst low mid-LOAD_BLUE, asynchronously between clock edges → all outputs zero immediately; no commit_new after release.
- With COEF_LOAD_CHECKSUM_EN and 16 words of 0x1000: COMMIT with [31:16]=0x0000 → commit_new. Reload the same words and COMMIT with 0x1234 → error=1, no pulse.
